cc_mim_microsequencer: RTL and testbench
========================================

# cc_mim_microsequencer

Microprogram sequencer for the microprogrammed ARC datapath. It holds the control-store address register (microPC) and drives the 11-bit address into the control store. Each cycle it reads back the 41-bit microword's COND and JUMP fields, the IR opcode bits and the PSR flags, and computes the next microaddress. It also stalls on memory microinstructions and freezes on an illegal (all-zero) microword.

## Interface
- DATAWIDTH_ADDR, 11, microaddress width (control-store input bus)
- DATAWIDTH_MICROWORD, 41, microword width (control-store output bus)
- DATAWIDTH_COUNT, 16, retired-microinstruction counter width
- CLOCK_50  in  1  system clock, rising edge
- RESET_InHigh  in  1  asynchronous, active-high reset
- microword_InBUS  in  41  current control-store word; fields: A[40:35] AMUX[34] B[33:28] BMUX[27] C[26:21] CMUX[20] RD[19] WR[18] ALU[17:14] COND[13:11] JUMP[10:0]
- ir_op_InBUS  in  2  IR[31:30]
- ir_op3_InBUS  in  6  IR[24:19]
- ir_bit13_In  in  1  IR[13] (immediate select)
- psr_nzvc_InBUS  in  4  {n,z,v,c} from PSR
- mem_ready_In  in  1  main memory completes current RD/WR this cycle
- microaddr_OutBUS  out  11  microPC, fed to control store
- commit_Out  out  1  current microword retires this cycle (datapath write-enable qualifier)
- halted_Out  out  1  sequencer frozen on illegal microword
- retired_count_OutBUS  out  16  retired-microinstruction counter

## Operation
- COND decode, jump target selection:
  - 000: NEXT = microPC+1
  - 001: JUMP if n
  - 010: JUMP if z
  - 011: JUMP if v
  - 100: JUMP if c
  - 101: JUMP if IR[13]
  - 110: JUMP unconditionally
  - 111: DECODE = {1'b1, IR[31:30], IR[24:19], 2'b00}
- A conditional branch that is not taken selects NEXT.
- NEXT is 11-bit modular: 2047+1 wraps to 0.
- FSM states:
  - RUN: microword not mem (RD=WR=0), or mem with mem_ready_In=1 → commit, load next address, stay RUN. Mem with mem_ready_In=0 → WAIT, microPC held, commit_Out=0.
  - WAIT: microPC held. mem_ready_In=1 → commit, load next address, RUN.
  - HALT: entered from RUN or WAIT when microword_InBUS==0 (checked before the memory test). microPC, counter and state are frozen; commit_Out=0 and halted_Out=1. Only reset exits.
- RD=WR=1 simultaneously is treated as a memory op (one ready handshake).
- retired_count increments by 1 on every commit and wraps modulo 2^16.

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream): microPC=0, state=RUN, retired_count=0, halted_Out=0, commit_Out=0 (combinational, follows state).
- microaddr_OutBUS is the microPC register output directly. The control store is combinational, so microword_InBUS is valid in the same cycle.
- Next-address logic is combinational. microPC updates on the rising edge after commit, giving one microinstruction per cycle when there are no stalls.
- commit_Out is combinational from state, microword and mem_ready_In. It is high in exactly the cycle whose edge advances microPC.
- Flags and IR are sampled in the commit cycle. A flag change in a WAIT cycle takes effect only through the final (ready) cycle's values.
- Reset asserted mid-WAIT or in HALT returns to microPC=0 immediately, with no pending commit.

## Structure
- Shared package cc_mim_pkg:
  - COND encodings (COND_NEXT … COND_DECODE)
  - microword field bit positions
  - state enum {RUN, WAIT, HALT}
  - reset microaddress 11'd0
- Sub-module cc_mim_next_address: purely combinational COND/flag/IR selector returning the 11-bit next address. The top holds the FSM, microPC, counter and commit logic.

## Test plan
- Reset at microPC=5, then release; microword at address 0 has COND=000 → microaddr goes 0, then 1 next cycle; retired_count=1; halted_Out=0.
- microPC=1024, COND=111, IR[31:30]=2'b10, IR[24:19]=6'b010000 → next microaddr=1600; with IR[31:30]=2'b11, op3=0 → 1792.
- COND=010, JUMP=12: z=1 → next=12; z=0 from microPC=8 → next=9. COND=101 with IR[13]=1 → JUMP taken.
- Microword RD=1, mem_ready_In=0 for 3 cycles then 1 → microPC held 3 cycles, commit_Out high only in the 4th cycle, retired_count increments once.
- microPC=2047, COND=000 → next microaddr=0.
- Microword all zero (undefined address, e.g. 13) → halted_Out=1 next cycle, microPC frozen at 13 for 10 cycles, commit_Out=0, counter unchanged; reset clears to microPC=0, halted_Out=0.

Source files
------------

// File: rtl/cc_mim_pkg.sv
// Shared definitions for the microprogrammed ARC sequencer: COND encodings,
// microword field positions, sequencer states and the reset microaddress.
package cc_mim_pkg;

    localparam int ADDR_W  = 11;
    localparam int WORD_W  = 41;
    localparam int COUNT_W = 16;

    localparam int F_RD      = 19;
    localparam int F_WR      = 18;
    localparam int F_COND_HI = 13;
    localparam int F_COND_LO = 11;
    localparam int F_JUMP_HI = 10;
    localparam int F_JUMP_LO = 0;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] RESET_UADDR = 11'd0;

endpackage

// File: rtl/cc_mim_next_address.sv
// Combinational next-microaddress selector: sequential, flag/IR13 branch,
// unconditional jump, or opcode-indexed DECODE dispatch.
module cc_mim_next_address
    import cc_mim_pkg::*;
(
    input  logic [ADDR_W-1:0] microaddr_InBUS,
    input  logic [2:0]        cond_InBUS,
    input  logic [ADDR_W-1:0] jump_InBUS,
    input  logic [1:0]        ir_op_InBUS,
    input  logic [5:0]        ir_op3_InBUS,
    input  logic              ir_bit13_In,
    input  logic [3:0]        psr_nzvc_InBUS,
    output logic [ADDR_W-1:0] next_addr_OutBUS
);

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] decode_addr;
    logic              taken;

    always_comb begin
        incr_addr   = microaddr_InBUS + 11'd1;
        // Opcode dispatch lands in the upper half, four words per op3 slot.
        decode_addr = {1'b1, ir_op_InBUS, ir_op3_InBUS, 2'b00};
        taken       = 1'b0;
        case (cond_e'(cond_InBUS))
            COND_N:    taken = psr_nzvc_InBUS[3];
            COND_Z:    taken = psr_nzvc_InBUS[2];
            COND_V:    taken = psr_nzvc_InBUS[1];
            COND_C:    taken = psr_nzvc_InBUS[0];
            COND_IR13: taken = ir_bit13_In;
            COND_JUMP: taken = 1'b1;
            default:   taken = 1'b0;
        endcase

        if (cond_e'(cond_InBUS) == COND_DECODE) begin
            next_addr_OutBUS = decode_addr;
        end else if (taken) begin
            next_addr_OutBUS = jump_InBUS;
        end else begin
            next_addr_OutBUS = incr_addr;
        end
    end

endmodule

// File: rtl/cc_mim_microsequencer.sv
// Microprogram sequencer: microPC register, memory-stall / illegal-word FSM
// and retired-microinstruction counter around the next-address selector.
module cc_mim_microsequencer
    import cc_mim_pkg::*;
#(
    parameter int DATAWIDTH_ADDR      = 11,
    parameter int DATAWIDTH_MICROWORD = 41,
    parameter int DATAWIDTH_COUNT     = 16
) (
    input  logic                           CLOCK_50,
    input  logic                           RESET_InHigh,
    input  logic [DATAWIDTH_MICROWORD-1:0] microword_InBUS,
    input  logic [1:0]                     ir_op_InBUS,
    input  logic [5:0]                     ir_op3_InBUS,
    input  logic                           ir_bit13_In,
    input  logic [3:0]                     psr_nzvc_InBUS,
    input  logic                           mem_ready_In,
    output logic [DATAWIDTH_ADDR-1:0]      microaddr_OutBUS,
    output logic                           commit_Out,
    output logic                           halted_Out,
    output logic [DATAWIDTH_COUNT-1:0]     retired_count_OutBUS
);

    state_e                     state_reg;
    state_e                     state_next;
    logic [DATAWIDTH_ADDR-1:0]  upc_reg;
    logic [DATAWIDTH_COUNT-1:0] count_reg;
    logic [DATAWIDTH_ADDR-1:0]  next_addr;
    logic                       commit;
    logic                       illegal_word;
    logic                       is_mem;

    cc_mim_next_address u_next_address (
        .microaddr_InBUS  (upc_reg),
        .cond_InBUS       (microword_InBUS[F_COND_HI:F_COND_LO]),
        .jump_InBUS       (microword_InBUS[F_JUMP_HI:F_JUMP_LO]),
        .ir_op_InBUS      (ir_op_InBUS),
        .ir_op3_InBUS     (ir_op3_InBUS),
        .ir_bit13_In      (ir_bit13_In),
        .psr_nzvc_InBUS   (psr_nzvc_InBUS),
        .next_addr_OutBUS (next_addr)
    );

    assign illegal_word = (microword_InBUS == '0);
    assign is_mem       = microword_InBUS[F_RD] | microword_InBUS[F_WR];

    // The illegal-word test takes priority over the memory handshake.
    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        case (state_reg)
            RUN: begin
                if (illegal_word) begin
                    state_next = HALT;
                end else if (!is_mem || mem_ready_In) begin
                    commit = 1'b1;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (illegal_word) begin
                    state_next = HALT;
                end else if (mem_ready_In) begin
                    commit     = 1'b1;
                    state_next = RUN;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            state_reg <= RUN;
            upc_reg   <= RESET_UADDR;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (commit) begin
                upc_reg   <= next_addr;
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // No commit is reported while reset holds the registers.
    assign commit_Out           = commit & ~RESET_InHigh;
    assign halted_Out           = (state_reg == HALT);
    assign microaddr_OutBUS     = upc_reg;
    assign retired_count_OutBUS = count_reg;

endmodule

// File: tb/tb_cc_mim_microsequencer.sv
// Bench for cc_mim_microsequencer: a control-store array feeds the DUT, and a
// cycle-level reference model checks microPC, commit, halt and counter.
module tb_cc_mim_microsequencer;

    logic        clk;
    logic        rst;
    logic [40:0] microword;
    logic [1:0]  ir_op;
    logic [5:0]  ir_op3;
    logic        ir_bit13;
    logic [3:0]  nzvc;
    logic        mem_ready;
    logic [10:0] microaddr;
    logic        commit;
    logic        halted;
    logic [15:0] count;

    logic [40:0] cs [0:2047];

    int n_checks = 0;
    int n_pass   = 0;
    int m_upc    = 0;
    int m_count  = 0;
    bit m_halted = 0;

    cc_mim_microsequencer dut (
        .CLOCK_50             (clk),
        .RESET_InHigh         (rst),
        .microword_InBUS      (microword),
        .ir_op_InBUS          (ir_op),
        .ir_op3_InBUS         (ir_op3),
        .ir_bit13_In          (ir_bit13),
        .psr_nzvc_InBUS       (nzvc),
        .mem_ready_In         (mem_ready),
        .microaddr_OutBUS     (microaddr),
        .commit_Out           (commit),
        .halted_Out           (halted),
        .retired_count_OutBUS (count)
    );

    assign microword = cs[microaddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Non-zero ALU field keeps every hand-built word legal.
    function automatic logic [40:0] mk(input bit rd, input bit wr, input logic [2:0] cond,
                                       input logic [10:0] jump);
        logic [40:0] w;
        w        = '0;
        w[17:14] = 4'b0101;
        w[19]    = rd;
        w[18]    = wr;
        w[13:11] = cond;
        w[10:0]  = jump;
        return w;
    endfunction

    function automatic int model_next(input logic [40:0] w, input int upc);
        bit take;
        case (int'(w[13:11]))
            1: take = nzvc[3];
            2: take = nzvc[2];
            3: take = nzvc[1];
            4: take = nzvc[0];
            5: take = ir_bit13;
            6: take = 1'b1;
            7: return 1024 + int'(ir_op) * 256 + int'(ir_op3) * 4;
            default: take = 1'b0;
        endcase
        if (take) return int'(w[10:0]);
        return (upc + 1) % 2048;
    endfunction

    // Called at a falling edge with inputs applied; returns at the next one.
    task automatic step();
        logic [40:0] w;
        bit          exp_commit;
        #1;
        w          = cs[m_upc];
        exp_commit = !m_halted && (w != 0) && (!(w[19] | w[18]) || mem_ready);
        check("uaddr", microaddr, m_upc);
        check("commit", commit, exp_commit);
        check("halted", halted, m_halted);
        check("count", count, m_count);
        if (!m_halted && w == 0) begin
            m_halted = 1;
        end else if (exp_commit) begin
            m_upc   = model_next(w, m_upc);
            m_count = (m_count + 1) % 65536;
        end
        @(negedge clk);
    endtask

    // Asserted off-edge to exercise the asynchronous path; released at a falling edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_uaddr", microaddr, 0);
        check("rst_commit", commit, 0);
        check("rst_halted", halted, 0);
        check("rst_count", count, 0);
        m_upc    = 0;
        m_count  = 0;
        m_halted = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic goto_addr(input int addr);
        cs[0] = mk(0, 0, 3'b110, addr[10:0]);
        do_reset();
        step();
    endtask

    task automatic rand_inputs();
        ir_op     = 2'($urandom);
        ir_op3    = 6'($urandom);
        ir_bit13  = 1'($urandom);
        nzvc      = 4'($urandom);
        mem_ready = 1'($urandom);
    endtask

    initial begin
        logic [40:0] w;
        rst = 1'b0;
        ir_op = '0; ir_op3 = '0; ir_bit13 = 1'b0; nzvc = '0; mem_ready = 1'b0;
        for (int i = 0; i < 2048; i++) cs[i] = mk(0, 0, 3'b000, 11'd0);
        @(negedge clk);

        // Reset from microPC=5, then one retirement.
        do_reset();
        repeat (5) step();
        check("pre_reset_uaddr", microaddr, 5);
        do_reset();
        step();
        check("post_reset_uaddr", microaddr, 1);
        check("post_reset_count", count, 1);
        check("post_reset_halted", halted, 0);

        // DECODE dispatch.
        cs[1024] = mk(0, 0, 3'b111, 11'd0);
        goto_addr(1024);
        ir_op = 2'b10; ir_op3 = 6'b010000;
        step();
        check("decode_1600", microaddr, 1600);
        goto_addr(1024);
        ir_op = 2'b11; ir_op3 = 6'b000000;
        step();
        check("decode_1792", microaddr, 1792);

        // Conditional branches.
        cs[8] = mk(0, 0, 3'b010, 11'd12);
        goto_addr(8);
        nzvc = 4'b0100;
        step();
        check("z_taken", microaddr, 12);
        goto_addr(8);
        nzvc = 4'b1011;
        step();
        check("z_not_taken", microaddr, 9);
        cs[8] = mk(0, 0, 3'b101, 11'd12);
        goto_addr(8);
        ir_bit13 = 1'b1;
        step();
        check("ir13_taken", microaddr, 12);

        // Memory stall for three cycles.
        cs[20] = mk(1, 0, 3'b000, 11'd0);
        goto_addr(20);
        mem_ready = 1'b0;
        repeat (3) begin
            #1 check("stall_no_commit", commit, 0);
            step();
            check("stall_hold_uaddr", microaddr, 20);
        end
        mem_ready = 1'b1;
        #1 check("stall_commit", commit, 1);
        step();
        check("stall_release_uaddr", microaddr, 21);
        check("stall_count", count, 2);

        // Address wrap.
        goto_addr(2047);
        step();
        check("wrap_uaddr", microaddr, 0);

        // Illegal word freezes the sequencer.
        cs[13] = '0;
        goto_addr(13);
        step();
        check("halt_flag", halted, 1);
        repeat (10) begin
            rand_inputs();
            step();
            check("halt_frozen_uaddr", microaddr, 13);
            check("halt_frozen_count", count, 1);
        end
        do_reset();
        check("halt_cleared", halted, 0);

        // Randomized control store and inputs, with occasional resets.
        for (int i = 0; i < 2048; i++) begin
            w = {9'($urandom), $urandom};
            if ($urandom_range(0, 3) != 0) w[19:18] = 2'b00;
            if ($urandom_range(0, 99) == 0) w = '0;
            else if (w == 0) w[40] = 1'b1;
            cs[i] = w;
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step();
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            else if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
